// File: rtl/nabp_mapper_pkg.sv
// Shared types, default widths and fixed-point helpers for the multi-channel
// projection mapper.
package nabp_mapper_pkg;

    typedef enum logic {
        READY   = 1'b0,
        MAPPING = 1'b1
    } mapper_state_e;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_LINE_SIZE = 256;
    localparam int DEF_S_W       = 8;
    localparam int DEF_ACCU_INT  = 10;
    localparam int DEF_ACCU_FRAC = 8;

    // Exclusive upper limit of a valid line position in accumulator units.
    function automatic int unsigned fx_upper_bound(input int unsigned line_size,
                                                   input int unsigned frac);
        return line_size << frac;
    endfunction

endpackage

// File: rtl/nabp_multi_mapper_if.sv
// Bundle between state control / shifter (master) and the mapper (slave).
// sh_kick is taken only while sh_ack is low; sh_ack high marks the pass, and
// sh_shift_en / sh_done act only while sh_ack is high.
interface nabp_multi_mapper_if #(
    parameter int NUM_CH = nabp_mapper_pkg::DEF_NUM_CH,
    parameter int S_W    = nabp_mapper_pkg::DEF_S_W,
    parameter int ACCU_W = nabp_mapper_pkg::DEF_ACCU_INT + nabp_mapper_pkg::DEF_ACCU_FRAC
);
    logic [NUM_CH*ACCU_W-1:0]      mp_accu_init;
    logic [ACCU_W-1:0]             mp_accu_base;
    logic                          sh_kick;
    logic                          sh_shift_en;
    logic                          sh_done;
    logic                          sh_ack;
    logic [NUM_CH*S_W-1:0]         fr_s_val;
    logic [NUM_CH-1:0]             fr_s_valid;
    logic [NUM_CH-1:0]             mp_overflow;
    nabp_mapper_pkg::mapper_state_e dbg_state;

    modport master (
        output mp_accu_init, mp_accu_base, sh_kick, sh_shift_en, sh_done,
        input  sh_ack, fr_s_val, fr_s_valid, mp_overflow, dbg_state
    );

    modport slave (
        input  mp_accu_init, mp_accu_base, sh_kick, sh_shift_en, sh_done,
        output sh_ack, fr_s_val, fr_s_valid, mp_overflow, dbg_state
    );

endinterface

// File: rtl/nabp_mapper_lane.sv
// One mapper channel: fixed-point accumulator, sticky signed-wrap flag,
// range check and registered address/valid outputs.
module nabp_mapper_lane
    import nabp_mapper_pkg::*;
#(
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int S_W       = DEF_S_W,
    parameter int ACCU_INT  = DEF_ACCU_INT,
    parameter int ACCU_FRAC = DEF_ACCU_FRAC,
    localparam int ACCU_W   = ACCU_INT + ACCU_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              active,
    input  logic [ACCU_W-1:0] init,
    input  logic [ACCU_W-1:0] base,
    output logic [S_W-1:0]    s_val,
    output logic              s_valid,
    output logic              overflow
);

    localparam int unsigned    UPPER_I = fx_upper_bound(LINE_SIZE, ACCU_FRAC);
    localparam logic [ACCU_W:0] UPPER  = UPPER_I[ACCU_W:0];

    logic [ACCU_W-1:0] accu_q, accu_d, sum;
    logic              ovf_q, ovf_d;
    logic [S_W-1:0]    s_val_q, s_val_d;
    logic              s_valid_q, s_valid_d;
    logic              wrap, in_range;

    assign sum  = accu_q + base;
    assign wrap = (accu_q[ACCU_W-1] == base[ACCU_W-1]) && (sum[ACCU_W-1] != accu_q[ACCU_W-1]);
    // Range uses the value before this cycle's step, so outputs lag accu by one edge.
    assign in_range = !accu_q[ACCU_W-1] && ({1'b0, accu_q} < UPPER) && !ovf_q;

    always_comb begin
        accu_d    = accu_q;
        ovf_d     = ovf_q;
        s_val_d   = '0;
        s_valid_d = 1'b0;
        if (load) begin
            accu_d = init;
            ovf_d  = 1'b0;
        end else if (step) begin
            accu_d = sum;
            if (wrap) ovf_d = 1'b1;
        end
        if (active && in_range) begin
            s_val_d   = accu_q[ACCU_FRAC +: S_W];
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accu_q    <= '0;
            ovf_q     <= 1'b0;
            s_val_q   <= '0;
            s_valid_q <= 1'b0;
        end else begin
            accu_q    <= accu_d;
            ovf_q     <= ovf_d;
            s_val_q   <= s_val_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign s_val    = s_val_q;
    assign s_valid  = s_valid_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/nabp_multi_mapper.sv
// Multi-channel projection mapper: READY/MAPPING control shared by NUM_CH
// independent lanes that step together on a common base.
module nabp_multi_mapper
    import nabp_mapper_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int S_W       = DEF_S_W,
    parameter int ACCU_INT  = DEF_ACCU_INT,
    parameter int ACCU_FRAC = DEF_ACCU_FRAC
) (
    input  logic               clk,
    input  logic               reset,
    nabp_multi_mapper_if.slave bus
);

    localparam int ACCU_W = ACCU_INT + ACCU_FRAC;

    mapper_state_e     state_q, state_d;
    logic              load, step, active;
    logic [S_W-1:0]    lane_s_val [NUM_CH];
    logic [NUM_CH-1:0] lane_valid;
    logic [NUM_CH-1:0] lane_ovf;

    always_comb begin
        state_d = state_q;
        case (state_q)
            READY:   if (bus.sh_kick) state_d = MAPPING;
            MAPPING: if (bus.sh_done) state_d = READY;
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= READY;
        else       state_q <= state_d;
    end

    assign active = (state_q == MAPPING);
    assign load   = (state_q == READY) && bus.sh_kick;
    assign step   = active && bus.sh_shift_en;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        nabp_mapper_lane #(
            .LINE_SIZE (LINE_SIZE),
            .S_W       (S_W),
            .ACCU_INT  (ACCU_INT),
            .ACCU_FRAC (ACCU_FRAC)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .step     (step),
            .active   (active),
            .init     (bus.mp_accu_init[k*ACCU_W +: ACCU_W]),
            .base     (bus.mp_accu_base),
            .s_val    (lane_s_val[k]),
            .s_valid  (lane_valid[k]),
            .overflow (lane_ovf[k])
        );
    end

    always_comb begin
        bus.fr_s_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.fr_s_val[k*S_W +: S_W] = lane_s_val[k];
        end
    end

    assign bus.fr_s_valid  = lane_valid;
    assign bus.mp_overflow = lane_ovf;
    assign bus.sh_ack      = active;
    assign bus.dbg_state   = state_q;

endmodule
